// File: rtl/cv32e40x_pkg.sv
// Shared definitions for the cv32e40x offload path.
// Holds the custom-opcode constants that identify offloaded instructions,
// and the state encoding of the XIF offload controller.
package cv32e40x_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
  localparam logic [6:0] OPCODE_CUSTOM1 = 7'h2B;
  localparam logic [6:0] OPCODE_CUSTOM2 = 7'h5B;
  localparam logic [6:0] OPCODE_CUSTOM3 = 7'h7B;

  typedef enum logic [2:0] {
    XIF_IDLE   = 3'd0,
    XIF_ISSUE  = 3'd1,
    XIF_COMMIT = 3'd2,
    XIF_RESULT = 3'd3,
    XIF_WB     = 3'd4
  } xif_offload_state_e;

endpackage

// File: rtl/cv32e40x_xif_offload.sv
// XIF offload controller: takes one instruction at a time from the core,
// issues it to the coprocessor, commits or kills it, collects the result
// and hands the write-back to the register file.
//
// state  | meaning
// IDLE   | ready for a core request
// ISSUE  | issue_valid_o asserted, waiting for issue_ready_i
// COMMIT | waiting for commit_go_i / kill_i (or a pending kill)
// RESULT | waiting for the coprocessor result with the issued ID
// WB     | wb_valid_o asserted, waiting for wb_ready_i
//
// Ports:
//   clk_i, rst_n                 clock, async active-low reset
//   req_*                        core offload request (instr, rs1, rs2)
//   commit_go_i, kill_i          core commit / flush
//   issue_*                      XIF issue channel
//   commit_*                     XIF commit channel
//   result_*                     XIF result channel
//   wb_*                         register-file write-back
//   illegal_o, result_err_o      one-cycle error pulses
module cv32e40x_xif_offload
  import cv32e40x_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_instr_i,
  input  logic [X_RFR_WIDTH-1:0] req_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] req_rs2_i,
  input  logic                   commit_go_i,
  input  logic                   kill_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [X_ID_WIDTH-1:0]  issue_id_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs0_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs1_o,
  output logic [1:0]             issue_rs_valid_o,
  input  logic                   issue_accept_i,
  input  logic                   issue_writeback_i,
  output logic                   commit_valid_o,
  output logic                   commit_kill_o,
  output logic [X_ID_WIDTH-1:0]  commit_id_o,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [X_ID_WIDTH-1:0]  result_id_i,
  input  logic [X_RFR_WIDTH-1:0] result_data_i,
  input  logic [4:0]             result_rd_i,
  input  logic                   result_we_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic [X_RFR_WIDTH-1:0] wb_data_o,
  output logic                   illegal_o,
  output logic                   result_err_o
);

  xif_offload_state_e state_q, state_d;

  logic [X_ID_WIDTH-1:0]  id_q;
  logic [X_ID_WIDTH-1:0]  issued_id;
  logic                   kill_pend_q;
  logic                   writeback_q;
  logic                   illegal_q;
  logic                   result_err_q;
  logic [31:0]            instr_q;
  logic [X_RFR_WIDTH-1:0] rs1_q;
  logic [X_RFR_WIDTH-1:0] rs2_q;
  logic [X_RFR_WIDTH-1:0] data_q;
  logic [4:0]             rd_q;

  logic in_idle, in_issue, in_commit, in_result;
  logic req_hs, issue_hs, result_hs, id_match;

  assign in_idle   = (state_q == XIF_IDLE);
  assign in_issue  = (state_q == XIF_ISSUE);
  assign in_commit = (state_q == XIF_COMMIT);
  assign in_result = (state_q == XIF_RESULT);

  // id_q is bumped on the accepted issue, so the in-flight ID is one behind.
  assign issued_id = id_q - X_ID_WIDTH'(1);

  assign req_hs    = in_idle & req_valid_i;
  assign issue_hs  = in_issue & issue_ready_i;
  assign result_hs = in_result & result_valid_i;
  assign id_match  = (result_id_i == issued_id);

  // rst_n gating keeps req_ready_o low while reset is held.
  assign req_ready_o      = rst_n & in_idle;
  assign issue_valid_o    = in_issue;
  assign issue_instr_o    = instr_q;
  assign issue_id_o       = id_q;
  assign issue_rs0_o      = rs1_q;
  assign issue_rs1_o      = rs2_q;
  assign issue_rs_valid_o = 2'b11;
  assign commit_valid_o   = in_commit & (commit_go_i | kill_i | kill_pend_q);
  assign commit_kill_o    = kill_i | kill_pend_q;
  assign commit_id_o      = issued_id;
  assign result_ready_o   = in_result;
  assign wb_valid_o       = (state_q == XIF_WB);
  assign wb_rd_o          = rd_q;
  assign wb_data_o        = data_q;
  assign illegal_o        = illegal_q;
  assign result_err_o     = result_err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      XIF_IDLE:   if (req_valid_i) state_d = XIF_ISSUE;
      XIF_ISSUE: begin
        if (issue_ready_i)  state_d = issue_accept_i ? XIF_COMMIT : XIF_IDLE;
        else if (kill_i)    state_d = XIF_IDLE;
      end
      XIF_COMMIT: begin
        if (kill_i | kill_pend_q) state_d = XIF_IDLE;
        else if (commit_go_i)     state_d = XIF_RESULT;
      end
      // A coprocessor that declared no write-back never reaches the RF.
      XIF_RESULT: if (result_valid_i && id_match)
                    state_d = (result_we_i && writeback_q) ? XIF_WB : XIF_IDLE;
      XIF_WB:     if (wb_ready_i) state_d = XIF_IDLE;
      default:    state_d = XIF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= XIF_IDLE;
      id_q         <= '0;
      kill_pend_q  <= 1'b0;
      writeback_q  <= 1'b0;
      illegal_q    <= 1'b0;
      result_err_q <= 1'b0;
      instr_q      <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      data_q       <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      illegal_q    <= issue_hs & ~issue_accept_i;
      result_err_q <= result_hs & ~id_match;
      if (req_hs) begin
        instr_q <= req_instr_i;
        rs1_q   <= req_rs1_i;
        rs2_q   <= req_rs2_i;
      end
      if (issue_hs && issue_accept_i) begin
        writeback_q <= issue_writeback_i;
        id_q        <= id_q + X_ID_WIDTH'(1);
        kill_pend_q <= kill_i;
      end else if (in_commit) begin
        kill_pend_q <= 1'b0;
      end
      if (result_hs && id_match) begin
        data_q <= result_data_i;
        rd_q   <= result_rd_i;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_xif_offload.sv
// Self-checking bench for cv32e40x_xif_offload: directed transactions plus
// randomized ones, checked against a transaction-level model of the ID counter.
module tb_cv32e40x_xif_offload;

  localparam int ID_W   = 4;
  localparam int RFR_W  = 32;
  localparam int ID_MOD = 1 << ID_W;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid_i = 1'b0, req_ready_o;
  logic [31:0]      req_instr_i = '0;
  logic [RFR_W-1:0] req_rs1_i = '0, req_rs2_i = '0;
  logic             commit_go_i = 1'b0, kill_i = 1'b0;
  logic             issue_valid_o, issue_ready_i = 1'b0;
  logic [31:0]      issue_instr_o;
  logic [ID_W-1:0]  issue_id_o;
  logic [RFR_W-1:0] issue_rs0_o, issue_rs1_o;
  logic [1:0]       issue_rs_valid_o;
  logic             issue_accept_i = 1'b0, issue_writeback_i = 1'b0;
  logic             commit_valid_o, commit_kill_o;
  logic [ID_W-1:0]  commit_id_o;
  logic             result_valid_i = 1'b0, result_ready_o;
  logic [ID_W-1:0]  result_id_i = '0;
  logic [RFR_W-1:0] result_data_i = '0;
  logic [4:0]       result_rd_i = '0;
  logic             result_we_i = 1'b0;
  logic             wb_valid_o, wb_ready_i = 1'b0;
  logic [4:0]       wb_rd_o;
  logic [RFR_W-1:0] wb_data_o;
  logic             illegal_o, result_err_o;

  cv32e40x_xif_offload #(.X_ID_WIDTH(ID_W), .X_RFR_WIDTH(RFR_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .commit_go_i(commit_go_i), .kill_i(kill_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_id_o(issue_id_o),
    .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o), .issue_rs_valid_o(issue_rs_valid_o),
    .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
    .commit_valid_o(commit_valid_o), .commit_kill_o(commit_kill_o), .commit_id_o(commit_id_o),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .result_id_i(result_id_i), .result_data_i(result_data_i),
    .result_rd_i(result_rd_i), .result_we_i(result_we_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .illegal_o(illegal_o), .result_err_o(result_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_id = 0;   // model: next ID the controller will issue

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    chk("issue_valid", issue_valid_o, 1);
    chk("issue_id", issue_id_o, exp_id);
    chk("issue_instr", issue_instr_o, instr);
    chk("issue_rs0", issue_rs0_o, rs1);
    chk("issue_rs1", issue_rs1_o, rs2);
    chk("issue_rs_valid", issue_rs_valid_o, 2'b11);
    chk("commit_in_issue", commit_valid_o, 0);
  endtask

  // kill_mode: 0 none, 1 kill while issue stalled, 2 kill on accepted handshake
  task automatic do_txn(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                        input bit accept, input int kill_mode, input int issue_wait,
                        input int go_wait, input bit bad_id, input bit we,
                        input logic [4:0] rd, input logic [31:0] data,
                        input int wb_wait, input bit rst_in_wb);
    int issued;
    req_valid_i = 1; req_instr_i = instr; req_rs1_i = rs1; req_rs2_i = rs2;
    @(negedge clk_i);
    chk("req_ready_idle", req_ready_o, 1);
    next_cycle();
    req_valid_i = 0; req_instr_i = $urandom; req_rs1_i = $urandom; req_rs2_i = $urandom;

    if (kill_mode == 1) begin
      kill_i = 1;
      @(negedge clk_i);
      chk_issue(instr, rs1, rs2);
      next_cycle();
      kill_i = 0;
      @(negedge clk_i);
      chk("issue_valid_killed", issue_valid_o, 0);
      chk("commit_after_kill", commit_valid_o, 0);
      chk("req_ready_after_kill", req_ready_o, 1);
      next_cycle();
      return;
    end

    for (int i = 0; i < issue_wait; i++) begin
      @(negedge clk_i);
      chk_issue(instr, rs1, rs2);
      next_cycle();
    end
    issue_ready_i = 1; issue_accept_i = accept; issue_writeback_i = 1; kill_i = (kill_mode == 2);
    @(negedge clk_i);
    chk_issue(instr, rs1, rs2);
    next_cycle();
    issue_ready_i = 0; issue_accept_i = 0; kill_i = 0;

    if (!accept) begin
      @(negedge clk_i);
      chk("illegal_pulse", illegal_o, 1);
      chk("commit_after_illegal", commit_valid_o, 0);
      chk("req_ready_after_illegal", req_ready_o, 1);
      next_cycle();
      @(negedge clk_i);
      chk("illegal_one_cycle", illegal_o, 0);
      next_cycle();
      return;
    end

    issued = exp_id;
    exp_id = (exp_id + 1) % ID_MOD;

    if (kill_mode == 2) begin
      @(negedge clk_i);
      chk("commit_valid_pend", commit_valid_o, 1);
      chk("commit_kill_pend", commit_kill_o, 1);
      chk("commit_id_pend", commit_id_o, issued);
      next_cycle();
      @(negedge clk_i);
      chk("commit_once", commit_valid_o, 0);
      chk("req_ready_after_killcommit", req_ready_o, 1);
      next_cycle();
      return;
    end

    for (int i = 0; i < go_wait; i++) begin
      @(negedge clk_i);
      chk("commit_early", commit_valid_o, 0);
      next_cycle();
    end
    commit_go_i = 1;
    @(negedge clk_i);
    chk("commit_valid", commit_valid_o, 1);
    chk("commit_kill", commit_kill_o, 0);
    chk("commit_id", commit_id_o, issued);
    next_cycle();
    commit_go_i = 0;

    if (bad_id) begin
      result_valid_i = 1;
      result_id_i = ID_W'((issued + 1 + $urandom_range(0, ID_MOD - 2)) % ID_MOD);
      result_data_i = $urandom; result_rd_i = 5'($urandom); result_we_i = 1;
      kill_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      chk("result_ready_bad", result_ready_o, 1);
      next_cycle();
      result_valid_i = 0; kill_i = 0;
      @(negedge clk_i);
      chk("result_err_pulse", result_err_o, 1);
      chk("result_ready_stay", result_ready_o, 1);
      next_cycle();
    end

    result_valid_i = 1; result_id_i = ID_W'(issued); result_data_i = data;
    result_rd_i = rd; result_we_i = we; kill_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    chk("result_ready", result_ready_o, 1);
    next_cycle();
    result_valid_i = 0; kill_i = 0; result_data_i = $urandom; result_rd_i = 5'($urandom);

    if (!we) begin
      @(negedge clk_i);
      chk("wb_valid_nowe", wb_valid_o, 0);
      chk("req_ready_nowe", req_ready_o, 1);
      chk("result_err_quiet", result_err_o, 0);
      next_cycle();
      return;
    end

    for (int i = 0; i < wb_wait; i++) begin
      @(negedge clk_i);
      chk("wb_valid_stall", wb_valid_o, 1);
      chk("wb_rd_stall", wb_rd_o, rd);
      chk("wb_data_stall", wb_data_o, data);
      chk("req_ready_in_wb", req_ready_o, 0);
      if (rst_in_wb) begin
        rst_n = 0;
        #1;
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_issue_valid", issue_valid_o, 0);
        chk("rst_result_ready", result_ready_o, 0);
        chk("rst_commit_valid", commit_valid_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        exp_id = 0;
        next_cycle();
        rst_n = 1;
        @(negedge clk_i);
        chk("rst_release_ready", req_ready_o, 1);
        chk("rst_release_id", issue_id_o, 0);
        next_cycle();
        return;
      end
      next_cycle();
    end
    wb_ready_i = 1;
    @(negedge clk_i);
    chk("wb_valid", wb_valid_o, 1);
    chk("wb_rd", wb_rd_o, rd);
    chk("wb_data", wb_data_o, data);
    chk("req_ready_in_wb", req_ready_o, 0);
    next_cycle();
    wb_ready_i = 0;
    @(negedge clk_i);
    chk("wb_valid_done", wb_valid_o, 0);
    chk("req_ready_after_wb", req_ready_o, 1);
    next_cycle();
  endtask

  task automatic rand_txn(input bit force_accept);
    bit accept;
    int km;
    accept = force_accept || ($urandom_range(0, 4) != 0);
    km = force_accept ? 0 : $urandom_range(0, 5);
    if (km > 2) km = 0;
    if (km == 2) accept = 1;
    do_txn($urandom, $urandom, $urandom, accept, km, $urandom_range(0, 2),
           $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
           5'($urandom), $urandom, $urandom_range(0, 2), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset_req_ready", req_ready_o, 0);
    chk("reset_issue_valid", issue_valid_o, 0);
    chk("reset_commit_valid", commit_valid_o, 0);
    chk("reset_result_ready", result_ready_o, 0);
    chk("reset_wb_valid", wb_valid_o, 0);
    chk("reset_illegal", illegal_o, 0);
    chk("reset_result_err", result_err_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_n = 1;
    @(negedge clk_i);
    chk("release_req_ready", req_ready_o, 1);
    chk("release_issue_id", issue_id_o, 0);
    next_cycle();

    // bring the ID to 3, then the reference transaction
    repeat (3) do_txn($urandom, $urandom, $urandom, 1, 0, 0, 0, 0, 1, 5'($urandom), $urandom, 0, 0);
    do_txn(32'h0000_002B, 32'h11, 32'h22, 1, 0, 0, 0, 0, 1, 5'd5, 32'hCAFE, 0, 0);
    // rejected instruction leaves the ID at 4
    do_txn(32'h0000_005B, 32'h1, 32'h2, 0, 0, 1, 0, 0, 1, 5'd1, 32'h1, 0, 0);
    // kill on a stalled issue, then kill coincident with acceptance
    do_txn($urandom, $urandom, $urandom, 1, 1, 0, 0, 0, 1, 5'd3, 32'h3, 0, 0);
    do_txn($urandom, $urandom, $urandom, 1, 2, 1, 0, 0, 1, 5'd3, 32'h3, 0, 0);
    // mismatched result ID, then the correct one
    do_txn($urandom, $urandom, $urandom, 1, 0, 0, 1, 1, 1, 5'd9, 32'h1234_5678, 1, 0);

    repeat (40) rand_txn(1'b0);

    // reset while write-back is stalled
    do_txn($urandom, $urandom, $urandom, 1, 0, 0, 0, 0, 1, 5'd7, 32'hBEEF, 2, 1);

    // ID wrap: 14 accepted to reach 0xE, then 15 more across the wrap
    repeat (29) rand_txn(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cv32e40x_xif_offload.md
CV32E40X_XIF_OFFLOAD -- requirements
Module: cv32e40x_xif_offload

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, XIF instruction ID width.
REQ-002 SHALL have parameter X_RFR_WIDTH, default 32, register read and result data width.
REQ-003 SHALL have ports (clock and reset first):
- clk_i  in  1  clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i / req_ready_o  in/out  1/1  core offload request handshake.
- req_instr_i  in  32  offloaded instruction.
- req_rs1_i / req_rs2_i  in  X_RFR_WIDTH  operand values.
- commit_go_i  in  1  core declares the instruction non-speculative.
- kill_i  in  1  core pipeline flush.
- issue_valid_o / issue_ready_i  out/in  1/1  XIF issue handshake.
- issue_instr_o  out  32  XIF issue instruction.
- issue_id_o  out  X_ID_WIDTH  XIF issue ID.
- issue_rs0_o / issue_rs1_o  out  X_RFR_WIDTH  XIF issue operands.
- issue_rs_valid_o  out  2  XIF operand valids.
- issue_accept_i / issue_writeback_i  in  1/1  coprocessor response, sampled at the issue handshake.
- commit_valid_o / commit_kill_o  out  1/1  XIF commit.
- commit_id_o  out  X_ID_WIDTH  XIF commit ID.
- result_valid_i / result_ready_o  in/out  1/1  XIF result handshake.
- result_id_i  in  X_ID_WIDTH  result ID.
- result_data_i  in  X_RFR_WIDTH  result data.
- result_rd_i  in  5  result destination register.
- result_we_i  in  1  result write enable.
- wb_valid_o / wb_ready_i  out/in  1/1  register-file writeback handshake.
- wb_rd_o  out  5  writeback destination register.
- wb_data_o  out  X_RFR_WIDTH  writeback data.
- illegal_o  out  1  one-cycle pulse: coprocessor rejected the instruction.
- result_err_o  out  1  one-cycle pulse: result ID mismatch.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, COMMIT, RESULT, WB, with at most one instruction outstanding.
REQ-005 IDLE: req_ready_o=1; req_valid_i SHALL latch instr, rs1, rs2 and id_q, then go to ISSUE; issue_valid_o rises the following cycle.
REQ-006 ISSUE: issue_valid_o=1, issue_id_o=id_q, issue_rs_valid_o=2'b11, with all issue fields held stable until issue_ready_i.
REQ-007 ISSUE handshake with accept=1 SHALL latch writeback, increment id_q modulo 2^X_ID_WIDTH (4'hF wraps to 4'h0), and go to COMMIT.
REQ-008 ISSUE handshake with accept=0 SHALL pulse illegal_o for one cycle, go to IDLE, and leave id_q unchanged.
REQ-009 kill_i in ISSUE without a handshake SHALL withdraw issue_valid_o next cycle and go to IDLE with no commit; kill_i coincident with an accepted handshake SHALL set kill_pend_q and go to COMMIT.
REQ-010 COMMIT: commit_valid_o SHALL be combinational and high for exactly one cycle when commit_go_i, kill_i or kill_pend_q is set; commit_kill_o=kill_i|kill_pend_q; commit_id_o is the issued ID.
REQ-011 After a kill commit the FSM SHALL go to IDLE; after a non-kill commit it SHALL go to RESULT; kill_i has priority over simultaneous commit_go_i.
REQ-012 RESULT: result_ready_o=1; kill_i SHALL be ignored; on a handshake with a matching ID, latch data, rd and we, then go to WB if we=1, otherwise to IDLE.
REQ-013 A result handshake with a mismatched ID SHALL pulse result_err_o and keep the FSM in RESULT.
REQ-014 WB: wb_valid_o=1 with latched rd and data, held until wb_ready_i, then go to IDLE; req_ready_o=0 in WB, giving a one-cycle bubble before the next request.
REQ-015 Minimum latency from request to writeback, with zero-wait responders, SHALL be 5 cycles.

Reset
REQ-016 Asserting rst_n SHALL force state IDLE, id_q=0 and kill_pend_q=0, and clear all data latches, in any state including mid-transaction.
REQ-017 During reset all valid, ready and pulse outputs SHALL be 0 except req_ready_o, which is 0 during reset and 1 in IDLE after release.

Structure
REQ-018 The state enum xif_offload_state_e SHALL live in cv32e40x_pkg, alongside the existing offload opcode constants.
REQ-019 The design SHALL use one state register and a separate next-state always_comb block, with no sub-module.

Verification
REQ-020 Request instr=0x0000_002B, rs1=0x11, rs2=0x22, id_q=3, accept=1, commit_go_i, result we=1, rd=5, data=0xCAFE -> issue_id_o=3, commit_id_o=3, commit_kill_o=0, wb_rd_o=5, wb_data_o=0xCAFE, id_q=4.
REQ-021 Issue with accept=0 -> illegal_o high for one cycle, no commit_valid_o, id_q unchanged.
REQ-022 kill_i during a stalled issue (issue_ready_i=0) -> issue_valid_o drops, no commit; kill_i on the accept cycle -> exactly one commit with commit_kill_o=1.
REQ-023 Fifteen back-to-back accepted instructions starting at id_q=0xE -> issued IDs wrap 0xE, 0xF, 0x0, ...
REQ-024 Result with ID 7 while 2 is expected -> result_err_o pulses; a later ID-2 result completes normally.
REQ-025 rst_n asserted in WB with wb_ready_i=0 -> wb_valid_o=0 immediately, state IDLE, id_q=0.
